// File: rtl/cheshire_fpga_rst_pkg.sv
// Shared types and sizing helpers for the Cheshire FPGA power-up / reset sequencer.
package cheshire_fpga_rst_pkg;

   // Sequencer states; the encoding is visible on state_o for ILA/VIO debug.
   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      WAIT_CALIB = 3'd1,
      HOLD       = 3'd2,
      RUN        = 3'd3,
      SOFT_RST   = 3'd4,
      ERROR      = 3'd5
   } rst_seq_state_e;

   // Width of the shared cycle counter: enough bits for the largest
   // cycle count plus one spare bit, so saturation never aliases a target.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c,
                                             input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/rst_seq_boot_latch.sv
// Boot-mode capture register: selects switch or VIO boot mode and holds it
// so the SoC sees a stable value across reset release.
module rst_seq_boot_latch
   import cheshire_fpga_rst_pkg::*;
(
   input  logic       soc_clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       sel,
   input  logic [1:0] sw_mode,
   input  logic [1:0] vio_mode,
   output logic [1:0] mode
);

   logic [1:0] mode_mux;

   assign mode_mux = sel ? vio_mode : sw_mode;

   // Capture the selected boot mode only when the sequencer asks for it.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         mode <= 2'b00;
      end else if (en) begin
         mode <= mode_mux;
      end
   end

endmodule

// File: rtl/cheshire_fpga_rst_seq.sv
// Power-up and reset sequencer for the Cheshire FPGA top level.
// Releases SoC/USB resets once the clock wizard is stably locked, DRAM
// calibration is done (when enabled) and a minimum hold time has elapsed.
// Optional feature macro: RST_SEQ_DDR_CALIB_EN enables the WAIT_CALIB state
// and its timeout; without it WAIT_LOCK proceeds straight to HOLD.
module cheshire_fpga_rst_seq
   import cheshire_fpga_rst_pkg::*;
#(
   parameter int unsigned LockStableCycles   = 256,
   parameter int unsigned CalibTimeoutCycles = 2000000,
   parameter int unsigned HoldCycles         = 64,
   parameter int unsigned SoftRstCycles      = 32
) (
   input  logic       soc_clk,
   input  logic       rst_n,
   input  logic       clk_locked_i,
   input  logic       ddr_calib_done_i,
   input  logic [1:0] boot_mode_i,
   input  logic [1:0] vio_boot_mode_i,
   input  logic       vio_boot_mode_sel_i,
   input  logic       soft_rst_req_i,
   output logic       soc_rst_no,
   output logic       usb_rst_no,
   output logic [1:0] boot_mode_o,
   output logic       ready_o,
   output logic       err_timeout_o,
   output logic [2:0] state_o
);

`ifdef RST_SEQ_DDR_CALIB_EN
   localparam int unsigned CntW = cnt_width(LockStableCycles, CalibTimeoutCycles,
                                            HoldCycles, SoftRstCycles);
`else
   localparam int unsigned CntW = cnt_width(LockStableCycles, 1,
                                            HoldCycles, SoftRstCycles);
`endif

   localparam logic [CntW-1:0] CntMax   = '1;
   localparam logic [CntW-1:0] LockLast = CntW'(LockStableCycles - 1);
   localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
   localparam logic [CntW-1:0] SoftLast = CntW'(SoftRstCycles - 1);
`ifdef RST_SEQ_DDR_CALIB_EN
   localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeoutCycles - 1);
`endif

   rst_seq_state_e  state;
   rst_seq_state_e  state_next;
   logic [CntW-1:0] cnt;
   logic            latch_en;

`ifndef RST_SEQ_DDR_CALIB_EN
   logic unused_calib;
   assign unused_calib = ddr_calib_done_i ^ (CalibTimeoutCycles == 32'd0);
`endif

   // Next-state selection; losing lock overrides every other event except in ERROR.
   always_comb begin
      state_next = state;
      case (state)
         WAIT_LOCK: begin
            if (clk_locked_i && (cnt == LockLast)) begin
`ifdef RST_SEQ_DDR_CALIB_EN
               state_next = WAIT_CALIB;
`else
               state_next = HOLD;
`endif
            end
         end
`ifdef RST_SEQ_DDR_CALIB_EN
         WAIT_CALIB: begin
            if (!clk_locked_i)          state_next = WAIT_LOCK;
            else if (ddr_calib_done_i)  state_next = HOLD;
            else if (cnt == CalibLast)  state_next = ERROR;
         end
         ERROR: begin
            state_next = ERROR;
         end
`endif
         HOLD: begin
            if (!clk_locked_i)         state_next = WAIT_LOCK;
            else if (cnt == HoldLast)  state_next = RUN;
         end
         RUN: begin
            if (!clk_locked_i)         state_next = WAIT_LOCK;
            else if (soft_rst_req_i)   state_next = SOFT_RST;
         end
         SOFT_RST: begin
            if (!clk_locked_i)         state_next = WAIT_LOCK;
            else if (cnt == SoftLast)  state_next = HOLD;
         end
         default: begin
            state_next = WAIT_LOCK;
         end
      endcase
   end

   // State register.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_LOCK;
      end else begin
         state <= state_next;
      end
   end

   // Shared cycle counter: restarts on every state change, and in WAIT_LOCK
   // also whenever lock drops so only consecutive locked cycles count.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_next != state) begin
         cnt <= '0;
      end else if ((state == WAIT_LOCK) && !clk_locked_i) begin
         cnt <= '0;
      end else if (cnt != CntMax) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Registered reset outputs: released only while the sequencer sits in RUN.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         soc_rst_no <= 1'b0;
         usb_rst_no <= 1'b0;
      end else begin
         soc_rst_no <= (state == RUN);
         usb_rst_no <= (state == RUN);
      end
   end

`ifdef RST_SEQ_DDR_CALIB_EN
   // Sticky timeout flag, raised together with the entry into ERROR.
   always_ff @(posedge soc_clk or negedge rst_n) begin
      if (!rst_n) begin
         err_timeout_o <= 1'b0;
      end else if (state_next == ERROR) begin
         err_timeout_o <= 1'b1;
      end
   end
`else
   assign err_timeout_o = 1'b0;
`endif

   // The first HOLD cycle is the only moment the boot mode is captured.
   assign latch_en = (state == HOLD) && (cnt == '0);

   rst_seq_boot_latch u_boot_latch (
      .soc_clk  (soc_clk),
      .rst_n    (rst_n),
      .en       (latch_en),
      .sel      (vio_boot_mode_sel_i),
      .sw_mode  (boot_mode_i),
      .vio_mode (vio_boot_mode_i),
      .mode     (boot_mode_o)
   );

   assign ready_o = (state == RUN);
   assign state_o = state;

endmodule

// File: tb/tb_cheshire_fpga_rst_seq.sv
// Self-checking bench for cheshire_fpga_rst_seq. Expected timings are derived
// arithmetically from the cycle-count parameters; boot mode from the mux rule.
module tb_cheshire_fpga_rst_seq;

   localparam int LOCK  = 256;
   localparam int CTO   = 50;
   localparam int HOLDC = 64;
   localparam int SOFTC = 32;
`ifdef RST_SEQ_DDR_CALIB_EN
   localparam int       CALIB_STEP = 1;
   localparam logic     CALIB_VAL  = 1'b1;
   localparam bit [2:0] AFTER_LOCK = 3'd1;
`else
   localparam int       CALIB_STEP = 0;
   localparam logic     CALIB_VAL  = 1'b0;
   localparam bit [2:0] AFTER_LOCK = 3'd2;
`endif
   localparam int TO_HOLD = LOCK + CALIB_STEP;
   localparam int TO_RUN  = TO_HOLD + HOLDC;
   localparam int SOFT_TO_RUN = SOFTC + HOLDC;

   logic       soc_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_locked_i = 1'b0;
   logic       ddr_calib_done_i = 1'b0;
   logic [1:0] boot_mode_i = 2'b00;
   logic [1:0] vio_boot_mode_i = 2'b00;
   logic       vio_boot_mode_sel_i = 1'b0;
   logic       soft_rst_req_i = 1'b0;
   logic       soc_rst_no;
   logic       usb_rst_no;
   logic [1:0] boot_mode_o;
   logic       ready_o;
   logic       err_timeout_o;
   logic [2:0] state_o;

   int passes = 0;
   int checks = 0;
   int now = 0;
   logic [1:0] exp_mode = 2'b00;

   always #5 soc_clk = ~soc_clk;

   cheshire_fpga_rst_seq #(
      .LockStableCycles   (LOCK),
      .CalibTimeoutCycles (CTO),
      .HoldCycles         (HOLDC),
      .SoftRstCycles      (SOFTC)
   ) dut (
      .soc_clk             (soc_clk),
      .rst_n               (rst_n),
      .clk_locked_i        (clk_locked_i),
      .ddr_calib_done_i    (ddr_calib_done_i),
      .boot_mode_i         (boot_mode_i),
      .vio_boot_mode_i     (vio_boot_mode_i),
      .vio_boot_mode_sel_i (vio_boot_mode_sel_i),
      .soft_rst_req_i      (soft_rst_req_i),
      .soc_rst_no          (soc_rst_no),
      .usb_rst_no          (usb_rst_no),
      .boot_mode_o         (boot_mode_o),
      .ready_o             (ready_o),
      .err_timeout_o       (err_timeout_o),
      .state_o             (state_o)
   );

   function automatic logic [1:0] pick_mode(input logic sel, input logic [1:0] vio,
                                            input logic [1:0] sw);
      return sel ? vio : sw;
   endfunction

   // Advance to observation point t (a negedge), counted from the last marker.
   task automatic goto_cycle(input int t);
      if (t > now) repeat (t - now) @(negedge soc_clk);
      now = t;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clk_locked_i = 1'b0;
      ddr_calib_done_i = 1'b0;
      soft_rst_req_i = 1'b0;
      repeat (2) @(negedge soc_clk);
      rst_n = 1'b1;
      exp_mode = 2'b00;
   endtask

   task automatic test_reset();
      int k;
      rst_n = 1'b0;
      @(negedge soc_clk);
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL rst_soc: got %b want 0", soc_rst_no); else passes++;
      checks++; if (usb_rst_no !== 1'b0) $display("[TB] FAIL rst_usb: got %b want 0", usb_rst_no); else passes++;
      checks++; if (boot_mode_o !== 2'b00) $display("[TB] FAIL rst_boot: got %b want 00", boot_mode_o); else passes++;
      checks++; if (ready_o !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", ready_o); else passes++;
      checks++; if (err_timeout_o !== 1'b0) $display("[TB] FAIL rst_err: got %b want 0", err_timeout_o); else passes++;
      checks++; if (state_o !== 3'd0) $display("[TB] FAIL rst_state: got %0d want 0", state_o); else passes++;
      // Random mid-operation asynchronous reset.
      rst_n = 1'b1;
      boot_mode_i = 2'($urandom_range(1, 3));
      vio_boot_mode_sel_i = 1'b0;
      clk_locked_i = 1'b1;
      ddr_calib_done_i = CALIB_VAL;
      k = $urandom_range(TO_HOLD + 2, TO_RUN + 30);
      now = 0;
      goto_cycle(k);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (state_o !== 3'd0) $display("[TB] FAIL async_state: got %0d want 0 (k=%0d)", state_o, k); else passes++;
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL async_soc: got %b want 0", soc_rst_no); else passes++;
      checks++; if (boot_mode_o !== 2'b00) $display("[TB] FAIL async_boot: got %b want 00", boot_mode_o); else passes++;
      checks++; if (ready_o !== 1'b0) $display("[TB] FAIL async_ready: got %b want 0", ready_o); else passes++;
      @(negedge soc_clk);
   endtask

   task automatic test_lock_glitch();
      int n;
      int len;
      do_reset();
      boot_mode_i = 2'b01;
      vio_boot_mode_i = 2'b10;
      vio_boot_mode_sel_i = 1'b1;
      exp_mode = pick_mode(1'b1, 2'b10, 2'b01);
      ddr_calib_done_i = CALIB_VAL;
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
         clk_locked_i = 1'b1;
         len = $urandom_range(10, 200);
         repeat (len) @(negedge soc_clk);
         checks++; if (state_o !== 3'd0) $display("[TB] FAIL glitch_state: got %0d want 0 (len=%0d)", state_o, len); else passes++;
         clk_locked_i = 1'b0;
         len = $urandom_range(1, 100);
         repeat (len) @(negedge soc_clk);
      end
      clk_locked_i = 1'b1;
      now = 0;
      goto_cycle(LOCK - 1);
      checks++; if (state_o !== 3'd0) $display("[TB] FAIL lock_early: got %0d want 0", state_o); else passes++;
      goto_cycle(LOCK);
      checks++; if (state_o !== AFTER_LOCK) $display("[TB] FAIL lock_done: got %0d want %0d", state_o, AFTER_LOCK); else passes++;
      goto_cycle(TO_HOLD);
      checks++; if (state_o !== 3'd2) $display("[TB] FAIL hold_entry: got %0d want 2", state_o); else passes++;
      goto_cycle(TO_RUN - 1);
      checks++; if (state_o !== 3'd2) $display("[TB] FAIL hold_end: got %0d want 2", state_o); else passes++;
      goto_cycle(TO_RUN);
      checks++; if (state_o !== 3'd3) $display("[TB] FAIL run_state: got %0d want 3", state_o); else passes++;
      checks++; if (ready_o !== 1'b1) $display("[TB] FAIL run_ready: got %b want 1", ready_o); else passes++;
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL run_soc_early: got %b want 0", soc_rst_no); else passes++;
      goto_cycle(TO_RUN + 1);
      checks++; if (soc_rst_no !== 1'b1) $display("[TB] FAIL run_soc: got %b want 1", soc_rst_no); else passes++;
      checks++; if (usb_rst_no !== 1'b1) $display("[TB] FAIL run_usb: got %b want 1", usb_rst_no); else passes++;
      checks++; if (boot_mode_o !== exp_mode) $display("[TB] FAIL boot_vio: got %b want %b", boot_mode_o, exp_mode); else passes++;
      checks++; if (err_timeout_o !== 1'b0) $display("[TB] FAIL run_err: got %b want 0", err_timeout_o); else passes++;
      // Switch changes in RUN must not disturb the latched mode.
      boot_mode_i = 2'b11;
      vio_boot_mode_sel_i = 1'b0;
      goto_cycle(TO_RUN + 11);
      checks++; if (boot_mode_o !== exp_mode) $display("[TB] FAIL boot_stable: got %b want %b", boot_mode_o, exp_mode); else passes++;
   endtask

   task automatic test_soft_reset();
      logic [1:0] new_mode;
      boot_mode_i = 2'($urandom);
      vio_boot_mode_i = 2'($urandom);
      vio_boot_mode_sel_i = 1'($urandom);
      new_mode = pick_mode(vio_boot_mode_sel_i, vio_boot_mode_i, boot_mode_i);
      soft_rst_req_i = 1'b1;
      now = -1;
      goto_cycle(0);
      soft_rst_req_i = 1'b0;
      checks++; if (state_o !== 3'd4) $display("[TB] FAIL soft_state: got %0d want 4", state_o); else passes++;
      checks++; if (soc_rst_no !== 1'b1) $display("[TB] FAIL soft_soc_reg: got %b want 1", soc_rst_no); else passes++;
      goto_cycle(1);
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL soft_soc: got %b want 0", soc_rst_no); else passes++;
      checks++; if (usb_rst_no !== 1'b0) $display("[TB] FAIL soft_usb: got %b want 0", usb_rst_no); else passes++;
      checks++; if (boot_mode_o !== exp_mode) $display("[TB] FAIL soft_boot_old: got %b want %b", boot_mode_o, exp_mode); else passes++;
      goto_cycle(SOFTC - 1);
      checks++; if (state_o !== 3'd4) $display("[TB] FAIL soft_end: got %0d want 4", state_o); else passes++;
      goto_cycle(SOFTC);
      checks++; if (state_o !== 3'd2) $display("[TB] FAIL soft_hold: got %0d want 2", state_o); else passes++;
      exp_mode = new_mode;
      goto_cycle(SOFTC + 8);
      checks++; if (boot_mode_o !== exp_mode) $display("[TB] FAIL soft_boot_new: got %b want %b", boot_mode_o, exp_mode); else passes++;
      goto_cycle(SOFT_TO_RUN);
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL soft_soc_low: got %b want 0", soc_rst_no); else passes++;
      checks++; if (ready_o !== 1'b1) $display("[TB] FAIL soft_ready: got %b want 1", ready_o); else passes++;
      goto_cycle(SOFT_TO_RUN + 1);
      checks++; if (soc_rst_no !== 1'b1) $display("[TB] FAIL soft_soc_back: got %b want 1", soc_rst_no); else passes++;
   endtask

   task automatic test_back_to_back();
      soft_rst_req_i = 1'b1;
      now = -1;
      goto_cycle(0);
      checks++; if (state_o !== 3'd4) $display("[TB] FAIL b2b_first: got %0d want 4", state_o); else passes++;
      goto_cycle(SOFT_TO_RUN);
      checks++; if (state_o !== 3'd3) $display("[TB] FAIL b2b_run: got %0d want 3", state_o); else passes++;
      goto_cycle(SOFT_TO_RUN + 1);
      checks++; if (state_o !== 3'd4) $display("[TB] FAIL b2b_retrig: got %0d want 4", state_o); else passes++;
      checks++; if (soc_rst_no !== 1'b1) $display("[TB] FAIL b2b_soc_pulse: got %b want 1", soc_rst_no); else passes++;
      soft_rst_req_i = 1'b0;
      goto_cycle(SOFT_TO_RUN + 2);
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL b2b_soc_low: got %b want 0", soc_rst_no); else passes++;
      goto_cycle(2 * SOFT_TO_RUN + 2);
      checks++; if (soc_rst_no !== 1'b1) $display("[TB] FAIL b2b_soc_back: got %b want 1", soc_rst_no); else passes++;
      checks++; if (state_o !== 3'd3) $display("[TB] FAIL b2b_settle: got %0d want 3", state_o); else passes++;
   endtask

   task automatic test_lock_loss_priority();
      clk_locked_i = 1'b0;
      soft_rst_req_i = 1'b1;
      now = -1;
      goto_cycle(0);
      soft_rst_req_i = 1'b0;
      checks++; if (state_o !== 3'd0) $display("[TB] FAIL loss_state: got %0d want 0", state_o); else passes++;
      checks++; if (ready_o !== 1'b0) $display("[TB] FAIL loss_ready: got %b want 0", ready_o); else passes++;
      goto_cycle(1);
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL loss_soc: got %b want 0", soc_rst_no); else passes++;
      checks++; if (usb_rst_no !== 1'b0) $display("[TB] FAIL loss_usb: got %b want 0", usb_rst_no); else passes++;
      checks++; if (state_o !== 3'd0) $display("[TB] FAIL loss_stay: got %0d want 0", state_o); else passes++;
   endtask

`ifdef RST_SEQ_DDR_CALIB_EN
   task automatic test_timeout();
      do_reset();
      clk_locked_i = 1'b1;
      ddr_calib_done_i = 1'b0;
      now = 0;
      goto_cycle(LOCK + CTO - 1);
      checks++; if (state_o !== 3'd1) $display("[TB] FAIL to_wait: got %0d want 1", state_o); else passes++;
      checks++; if (err_timeout_o !== 1'b0) $display("[TB] FAIL to_err_early: got %b want 0", err_timeout_o); else passes++;
      goto_cycle(LOCK + CTO);
      checks++; if (state_o !== 3'd5) $display("[TB] FAIL to_error: got %0d want 5", state_o); else passes++;
      checks++; if (err_timeout_o !== 1'b1) $display("[TB] FAIL to_err: got %b want 1", err_timeout_o); else passes++;
      clk_locked_i = 1'b0;
      goto_cycle(LOCK + CTO + $urandom_range(3, 20));
      clk_locked_i = 1'b1;
      ddr_calib_done_i = 1'b1;
      goto_cycle(now + 10);
      checks++; if (state_o !== 3'd5) $display("[TB] FAIL to_sticky_state: got %0d want 5", state_o); else passes++;
      checks++; if (err_timeout_o !== 1'b1) $display("[TB] FAIL to_sticky_err: got %b want 1", err_timeout_o); else passes++;
      checks++; if (soc_rst_no !== 1'b0) $display("[TB] FAIL to_soc: got %b want 0", soc_rst_no); else passes++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (err_timeout_o !== 1'b0) $display("[TB] FAIL to_clear_err: got %b want 0", err_timeout_o); else passes++;
      checks++; if (state_o !== 3'd0) $display("[TB] FAIL to_clear_state: got %0d want 0", state_o); else passes++;
      @(negedge soc_clk);
      // Calibration arriving on the timeout cycle wins.
      do_reset();
      clk_locked_i = 1'b1;
      ddr_calib_done_i = 1'b0;
      now = 0;
      goto_cycle(LOCK + CTO - 1);
      ddr_calib_done_i = 1'b1;
      goto_cycle(LOCK + CTO);
      checks++; if (state_o !== 3'd2) $display("[TB] FAIL tie_state: got %0d want 2", state_o); else passes++;
      checks++; if (err_timeout_o !== 1'b0) $display("[TB] FAIL tie_err: got %b want 0", err_timeout_o); else passes++;
   endtask
`else
   task automatic test_no_calib();
      do_reset();
      clk_locked_i = 1'b1;
      now = 0;
      for (int i = 1; i <= TO_RUN + 1; i++) begin
         ddr_calib_done_i = 1'($urandom);
         goto_cycle(i);
      end
      checks++; if (soc_rst_no !== 1'b1) $display("[TB] FAIL nocal_soc: got %b want 1", soc_rst_no); else passes++;
      checks++; if (state_o !== 3'd3) $display("[TB] FAIL nocal_state: got %0d want 3", state_o); else passes++;
      ddr_calib_done_i = 1'b0;
      goto_cycle(TO_RUN + 200);
      checks++; if (err_timeout_o !== 1'b0) $display("[TB] FAIL nocal_err: got %b want 0", err_timeout_o); else passes++;
      checks++; if (ready_o !== 1'b1) $display("[TB] FAIL nocal_ready: got %b want 1", ready_o); else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_lock_glitch();
      test_soft_reset();
      test_back_to_back();
      test_lock_loss_priority();
`ifdef RST_SEQ_DDR_CALIB_EN
      test_timeout();
`else
      test_no_calib();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/cheshire_fpga_rst_seq.md
Name: cheshire_fpga_rst_seq

Overview:
Power-up and reset sequencer for the FPGA top level, clocked by soc_clk.
- Gates SoC and USB reset release on three conditions: clock-wizard lock stable, DRAM MIG calibration complete, and a minimum hold time elapsed.
- Latches the effective boot mode (switch or VIO override) so it is stable before reset release.
- Provides a software/VIO soft-reset path.
- Reports progress and timeout errors for debug.

Parameters:
LockStableCycles, 256, consecutive cycles clk_locked_i must be high before leaving WAIT_LOCK (>=1)
CalibTimeoutCycles, 2000000, max cycles in WAIT_CALIB before entering ERROR (>=1)
HoldCycles, 64, cycles in HOLD with resets asserted before RUN (>=1)
SoftRstCycles, 32, cycles in SOFT_RST with resets asserted (>=1)

Ports:
soc_clk  in  1  sequencer clock
rst_n  in  1  async active-low reset
clk_locked_i  in  1  clock wizard locked, already synchronized to soc_clk
ddr_calib_done_i  in  1  MIG calibration done, already synchronized to soc_clk
boot_mode_i  in  2  switch boot mode
vio_boot_mode_i  in  2  VIO boot mode
vio_boot_mode_sel_i  in  1  1 = use VIO boot mode
soft_rst_req_i  in  1  soft reset request, level or pulse
soc_rst_no  out  1  SoC reset, active-low, registered
usb_rst_no  out  1  USB domain reset, active-low, registered
boot_mode_o  out  2  latched boot mode
ready_o  out  1  high in RUN
err_timeout_o  out  1  sticky calibration-timeout flag
state_o  out  3  current FSM state encoding, for ILA/VIO

Behaviour:
Interface:
- Reset rst_n is asynchronous, active-low; clock is soc_clk.

Reset values:
- soc_rst_no=0, usb_rst_no=0, boot_mode_o=0, ready_o=0, err_timeout_o=0.
- state=WAIT_LOCK, counter=0.

State encoding:
- WAIT_LOCK=0, WAIT_CALIB=1, HOLD=2, RUN=3, SOFT_RST=4, ERROR=5.

Counter:
- Single shared counter, width $clog2(max of all params)+1.
- Cleared on every state transition.
- Saturates at max; never wraps.

Transitions:
- WAIT_LOCK: counter increments while clk_locked_i=1 and clears when it is 0. When counter==LockStableCycles-1 with lock high, go to WAIT_CALIB.
- WAIT_CALIB: on ddr_calib_done_i=1, go to HOLD. If counter==CalibTimeoutCycles-1 without calib, go to ERROR.
- HOLD: on the entry cycle, boot_mode_o <= vio_boot_mode_sel_i ? vio_boot_mode_i : boot_mode_i. boot_mode_o does not change at any other time. After HoldCycles cycles, go to RUN.
- RUN: soc_rst_no=1, usb_rst_no=1, ready_o=1. On soft_rst_req_i=1, go to SOFT_RST.
- SOFT_RST: after SoftRstCycles cycles, go to HOLD, which re-latches boot mode. soft_rst_req_i held high re-triggers only after RUN is re-entered, so a level request causes repeated soft resets.
- ERROR: err_timeout_o <= 1. Resets stay asserted. Leaves only via rst_n. clk_locked_i loss is ignored.

Output timing:
- Resets are asserted in every state except RUN.
- soc_rst_no and usb_rst_no are registered: they rise the cycle after the state register becomes RUN and fall the cycle after leaving RUN.

Priority when events coincide:
- Lock loss (clk_locked_i=0) in WAIT_CALIB/HOLD/RUN/SOFT_RST goes to WAIT_LOCK. It has priority over every other transition, including soft_rst_req_i and the calibration timeout.
- Calib done and timeout in the same cycle: calib wins, go to HOLD.
- ddr_calib_done_i dropping after WAIT_CALIB is ignored.

Async reset mid-operation:
- rst_n assertion returns all state and outputs to reset values immediately.

Optional Feature:
Macro RST_SEQ_DDR_CALIB_EN.
- Defined: WAIT_CALIB state and timeout as above.
- Undefined: WAIT_LOCK goes directly to HOLD. ddr_calib_done_i is ignored. ERROR is unreachable, err_timeout_o is tied to 0, and CalibTimeoutCycles is excluded from counter width sizing.

Decomposition:
- Shared package cheshire_fpga_rst_pkg holds:
  - state enum rst_seq_state_e (3-bit, encodings above);
  - localparam function for counter width.
- Sub-module rst_seq_boot_latch: 2-bit mux plus enable register for boot mode; instantiated once.
- FSM and counter stay in the top module.

Test Plan:
1. Lock toggles 0/1 every 100 cycles, then goes high steadily. Params 256/50/64/32, calib done from cycle 0. Expect: WAIT_CALIB exactly 256 cycles after the last rise, soc_rst_no=1 at 256+1+64+1 cycles, ready_o=1.
2. Lock stable, calib never arrives, CalibTimeoutCycles=50. Expect: ERROR 50 cycles after entering WAIT_CALIB, err_timeout_o=1 and sticky, resets held 0. Pulse rst_n: all outputs cleared.
3. In HOLD, switches=2'b01 and VIO=2'b10 with sel=1. Expect: boot_mode_o=2'b10. Change switches in RUN: boot_mode_o unchanged.
4. One-cycle soft_rst_req_i in RUN. Expect: soc_rst_no=0 for 32+64 cycles, then back to RUN with ready_o=1. Boot mode is re-latched.
5. Drop clk_locked_i in RUN in the same cycle as soft_rst_req_i. Expect: WAIT_LOCK, not SOFT_RST. Resets asserted the next cycle.
6. Build without RST_SEQ_DDR_CALIB_EN, ddr_calib_done_i=0. Expect: reaches RUN after lock+hold, err_timeout_o stays 0.
